adder_arbiter: RTL and testbench



---
 rtl/adder_arbiter.sv | 128 ++++++++++++
 tb/tb_adder_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester round-robin front end for one shared
// combinational adder.
//
// Each requester offers an operand pair on a valid/ready handshake. While the
// block is idle it grants one requester, steers that requester's operands
// into the shared adder and registers the sum on the accept edge. The result
// is then held on res_suma/res_id with res_valid until the consumer takes it
// with res_ready, after which the block returns to idle. One operation
// completes at most every two cycles.
//
// Ports:
//   clk                     clock, rising edge
//   rst                     asynchronous active-high reset
//   req0_valid/a/b, ready   requester 0 handshake and operands
//   req1_valid/a/b, ready   requester 1 handshake and operands
//   res_valid/suma/id       registered result, N+1 bit sum, owner ID
//   res_ready               consumer accepts result
//   op_cnt                  count of consumed results, wraps modulo 2^CNT_W

// Shared unsigned adder, full-width result with no truncation.
module adder #(
    parameter int N = 3
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   suma
);
    assign suma = {1'b0, a} + {1'b0, b};
endmodule

module adder_arbiter #(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [N-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [N-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [N:0]       res_suma,
    output logic             res_id,
    input  logic             res_ready,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t       state;
    logic         last_grant;
    logic         grant0;
    logic         grant1;
    logic         accept;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic [N:0]   add_suma;

    // Winner selection. On a tie the requester not served last wins, which
    // is what makes back-to-back contention alternate.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign accept     = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Only the winner's operands reach the adder; when nobody is granted the
    // adder output is simply not captured.
    assign add_a = grant1 ? req1_a : req0_a;
    assign add_b = grant1 ? req1_b : req0_b;

    adder #(.N(N)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .suma (add_suma)
    );

    // Accept edge captures the sum; drain edge releases the result.
    // res_suma/res_id keep their last value after the drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            res_valid  <= 1'b0;
            res_suma   <= '0;
            res_id     <= 1'b0;
            op_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        res_suma   <= add_suma;
                        res_id     <= grant1;
                        last_grant <= grant1;
                        res_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        op_cnt    <= op_cnt + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

    localparam int N     = 3;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             req0_valid;
    logic [N-1:0]     req0_a;
    logic [N-1:0]     req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [N-1:0]     req1_a;
    logic [N-1:0]     req1_b;
    logic             req1_ready;
    logic             res_valid;
    logic [N:0]       res_suma;
    logic             res_id;
    logic             res_ready;
    logic [CNT_W-1:0] op_cnt;

    int total = 0;
    int bad   = 0;
    int cnt_exp = 0;

    adder_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_suma   (res_suma),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .op_cnt     (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [2:0] a0;
        logic [2:0] b0;
        logic       v1;
        logic [2:0] a1;
        logic [2:0] b1;
        logic       e_r0;
        logic       e_r1;
        logic [3:0] e_sum;
        logic       e_id;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the random phase
    bit m_busy;
    int m_last;
    int m_cnt;
    int m_sum;
    int m_id;

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0;
        res_ready = 0;

        tbl[0] = '{1, 3, 2, 0, 0, 0, 1, 0, 5, 0};
        tbl[1] = '{0, 0, 0, 1, 7, 7, 0, 1, 14, 1};
        tbl[2] = '{0, 0, 0, 1, 0, 1, 0, 1, 1, 1};
        tbl[3] = '{1, 4, 4, 1, 2, 5, 1, 0, 8, 0};
        tbl[4] = '{1, 4, 4, 1, 2, 5, 0, 1, 7, 1};
        tbl[5] = '{1, 7, 0, 0, 0, 0, 1, 0, 7, 0};

        #12;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_suma", res_suma, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_op_cnt", op_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        // Table: one accept/drain per row, op_cnt wraps through 1,2,3,0,1,2
        for (int i = 0; i < 6; i++) begin
            req0_valid = tbl[i].v0; req0_a = tbl[i].a0; req0_b = tbl[i].b0;
            req1_valid = tbl[i].v1; req1_a = tbl[i].a1; req1_b = tbl[i].b1;
            res_ready = 0;
            @(negedge clk);
            chk($sformatf("tbl%0d_req0_ready", i), req0_ready, tbl[i].e_r0);
            chk($sformatf("tbl%0d_req1_ready", i), req1_ready, tbl[i].e_r1);
            next_cycle();
            req0_valid = 0; req1_valid = 0;
            @(negedge clk);
            chk($sformatf("tbl%0d_res_valid", i), res_valid, 1);
            chk($sformatf("tbl%0d_res_suma", i), res_suma, tbl[i].e_sum);
            chk($sformatf("tbl%0d_res_id", i), res_id, tbl[i].e_id);
            chk($sformatf("tbl%0d_op_cnt_hold", i), op_cnt, cnt_exp);
            res_ready = 1;
            next_cycle();
            res_ready = 0;
            cnt_exp = (cnt_exp + 1) % 4;
            @(negedge clk);
            chk($sformatf("tbl%0d_res_valid_drop", i), res_valid, 0);
            chk($sformatf("tbl%0d_op_cnt", i), op_cnt, cnt_exp);
            next_cycle();
        end

        // Backpressure: result held for 5 cycles with both requesters waiting
        req0_valid = 1; req0_a = 1; req0_b = 1;
        req1_valid = 0; res_ready = 0;
        next_cycle();
        req1_valid = 1; req0_a = 6; req1_a = 5; req1_b = 5;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_suma", res_suma, 2);
            chk("bp_req0_ready", req0_ready, 0);
            chk("bp_req1_ready", req1_ready, 0);
            chk("bp_op_cnt", op_cnt, cnt_exp);
            next_cycle();
        end
        req0_valid = 0; req1_valid = 0; res_ready = 1;
        next_cycle();
        res_ready = 0;
        cnt_exp = (cnt_exp + 1) % 4;
        @(negedge clk);
        chk("bp_drain_valid", res_valid, 0);
        chk("bp_drain_op_cnt", op_cnt, cnt_exp);
        next_cycle();

        // Asynchronous reset while a result is pending
        req0_valid = 1; req0_a = 2; req0_b = 3;
        next_cycle();
        req0_valid = 0;
        @(negedge clk);
        chk("ar_pre_valid", res_valid, 1);
        chk("ar_pre_suma", res_suma, 5);
        #2 rst = 1'b1;
        #1;
        chk("ar_res_valid", res_valid, 0);
        chk("ar_op_cnt", op_cnt, 0);
        chk("ar_res_suma", res_suma, 0);
        cnt_exp = 0;
        next_cycle();
        rst = 1'b0;
        req0_valid = 1; req0_a = 4; req0_b = 4;
        req1_valid = 1; req1_a = 1; req1_b = 2;
        @(negedge clk);
        chk("ar_tie_req0_ready", req0_ready, 1);
        chk("ar_tie_req1_ready", req1_ready, 0);
        next_cycle();
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        chk("ar_tie_suma", res_suma, 8);
        chk("ar_tie_id", res_id, 0);
        res_ready = 1;
        next_cycle();
        res_ready = 0;
        cnt_exp = 1;

        // Randomized phase against the reference model
        m_busy = 0; m_last = 0; m_cnt = cnt_exp; m_sum = 0; m_id = 0;
        for (int c = 0; c < 400; c++) begin
            int win;
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = N'($urandom); req0_b = N'($urandom);
            req1_a = N'($urandom); req1_b = N'($urandom);
            res_ready = ($urandom_range(0, 2) != 0);
            win = -1;
            if (!m_busy) begin
                if (req0_valid && req1_valid) win = 1 - m_last;
                else if (req0_valid) win = 0;
                else if (req1_valid) win = 1;
            end
            @(negedge clk);
            chk("rnd_req0_ready", req0_ready, (win == 0) ? 1 : 0);
            chk("rnd_req1_ready", req1_ready, (win == 1) ? 1 : 0);
            chk("rnd_res_valid", res_valid, m_busy ? 1 : 0);
            if (m_busy) begin
                chk("rnd_res_suma", res_suma, m_sum);
                chk("rnd_res_id", res_id, m_id);
            end
            chk("rnd_op_cnt", op_cnt, m_cnt);
            @(posedge clk);
            if (win == 0) begin
                m_busy = 1; m_sum = req0_a + req0_b; m_id = 0; m_last = 0;
            end else if (win == 1) begin
                m_busy = 1; m_sum = req1_a + req1_b; m_id = 1; m_last = 1;
            end else if (m_busy && res_ready) begin
                m_busy = 0; m_cnt = (m_cnt + 1) % 4;
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
